bnn_job_arbiter: RTL and testbench

BNN_JOB_ARBITER -- requirements
Module: bnn_job_arbiter

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_job_arbiter_if.sv | 26 ++
 rtl/bnn_rr_pick.sv | 11 +
 rtl/bnn_job_arbiter.sv | 143 ++++++++++++++
 tb/tb_bnn_job_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN job arbiter.
// Holds the FSM state encoding and result/image widths.
package bnn_pkg;

  localparam int IMG_BITS = 904;
  localparam int RESULT_BITS = 4;
  localparam logic [RESULT_BITS-1:0] ERR_RESULT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CLEAR,
    S_RESP
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bnn_job_arbiter_if.sv
// Requester-side job bus: request/image in, ack, result handshake out.
// master = requesters, slave = arbiter.
interface bnn_job_arbiter_if #(
  parameter int IMG_BITS = 904
);

  logic [1:0]          req;
  logic [IMG_BITS-1:0] img0;
  logic [IMG_BITS-1:0] img1;
  logic [1:0]          ack;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [3:0]          resp_result;
  logic                resp_error;

  modport master (
    output req, img0, img1, resp_ready,
    input  ack, resp_valid, resp_result, resp_error
  );

  modport slave (
    input  req, img0, img1, resp_ready,
    output ack, resp_valid, resp_result, resp_error
  );

endinterface

// File: rtl/bnn_rr_pick.sv
// Two-way round-robin pick: on contention the side not granted last wins.
// grant is the winning requester index.
module bnn_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  assign grant = (&req) ? ~last : req[1];

endmodule

// File: rtl/bnn_job_arbiter.sv
// Arbitrates two requesters onto one BNN inference engine,
// with a per-job timeout and a result handshake back to the owner.
module bnn_job_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IMG_BITS = 904
) (
  input  logic clk,
  input  logic rst_n,
  bnn_job_arbiter_if.slave job,
  output logic [IMG_BITS-1:0] eng_img,
  output logic eng_buffer_full,
  output logic eng_enable,
  output logic eng_clear,
  input  logic eng_result_ready,
  input  logic [bnn_pkg::RESULT_BITS-1:0] eng_result,
  output logic busy,
  output logic [7:0] timeout_cnt
);
  import bnn_pkg::*;

  localparam logic [15:0] CNT_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_n;

  logic owner_q, owner_n;
  logic last_q, last_n;
  logic grant, cap;
  logic [15:0] cnt_q, cnt_n;
  logic [RESULT_BITS-1:0] res_q, res_n;
  logic err_q, err_n;
  logic [7:0] tocnt_q, tocnt_n;

  logic [1:0] ack_q, rv_q;
  logic en_q, clr_q, busy_q;
  logic [IMG_BITS-1:0] img_q;

  bnn_rr_pick u_pick (
    .req   (job.req),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    res_n   = res_q;
    err_n   = err_q;
    tocnt_n = tocnt_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|job.req) begin
          owner_n = grant;
          cap     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_n   = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        cnt_n = cnt_q + 16'd1;
        // a result on the last allowed cycle beats the timeout
        if (eng_result_ready) begin
          res_n   = eng_result;
          err_n   = 1'b0;
          state_n = S_CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          res_n   = ERR_RESULT;
          err_n   = 1'b1;
          if (tocnt_q != 8'hFF)
            tocnt_n = tocnt_q + 8'd1;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: state_n = S_RESP;
      S_RESP: begin
        if (job.resp_ready[owner_q]) begin
          last_n  = owner_q;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tocnt_q <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      img_q   <= '0;
    end else begin
      owner_q <= owner_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      res_q   <= res_n;
      err_q   <= err_n;
      tocnt_q <= tocnt_n;
      ack_q   <= (state_n == S_LOAD) ?
                 onehot2(owner_n) : 2'b00;
      rv_q    <= (state_n == S_RESP) ?
                 onehot2(owner_n) : 2'b00;
      en_q    <= (state_n == S_LOAD) ||
                 (state_n == S_RUN);
      clr_q   <= (state_n == S_CLEAR);
      busy_q  <= (state_n != S_IDLE);
      if (cap)
        img_q <= grant ? job.img1 : job.img0;
    end
  end

  assign job.ack         = ack_q;
  assign job.resp_valid  = rv_q;
  assign job.resp_result = res_q;
  assign job.resp_error  = err_q;

  assign eng_img         = img_q;
  assign eng_enable      = en_q;
  assign eng_buffer_full = en_q;
  assign eng_clear       = clr_q;
  assign busy            = busy_q;
  assign timeout_cnt     = tocnt_q;

endmodule

// File: tb/tb_bnn_job_arbiter.sv
// Bench for bnn_job_arbiter: job-timeline reference model checked every
// cycle, plus directed jobs, contention, timeout, backpressure and reset.
module tb_bnn_job_arbiter;

  localparam int TO = 16;
  localparam int IB = 904;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_job_arbiter_if #(.IMG_BITS(IB)) jif();

  logic [IB-1:0] eng_img;
  logic eng_buffer_full, eng_enable, eng_clear;
  logic eng_result_ready;
  logic [3:0] eng_result;
  logic busy;
  logic [7:0] timeout_cnt;

  bnn_job_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .IMG_BITS(IB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .job              (jif),
    .eng_img          (eng_img),
    .eng_buffer_full  (eng_buffer_full),
    .eng_enable       (eng_enable),
    .eng_clear        (eng_clear),
    .eng_result_ready (eng_result_ready),
    .eng_result       (eng_result),
    .busy             (busy),
    .timeout_cnt      (timeout_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_img(input string nm, input logic [IB-1:0] act,
                         input logic [IB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IB-1:0] rand_img();
    logic [927:0] t;
    for (int w = 0; w < 29; w++) t[w*32 +: 32] = $urandom;
    return t[IB-1:0];
  endfunction

  function automatic logic [1:0] oh(input bit i);
    return i ? 2'b10 : 2'b01;
  endfunction

  // Reference model: a job is a timeline counted from its ack cycle (t=0).
  // Engine time runs from t=1 until decision cycle r; clear at r+1;
  // response offered from r+2 until the owner accepts.
  bit            m_job = 0;
  bit            m_owner = 0;
  int            m_t = 0;
  bit            m_dec = 0;
  int            m_r = 0;
  logic [3:0]    m_res = '0;
  bit            m_err = 0;
  bit            m_last = 1;
  int            m_tocnt = 0;
  logic [IB-1:0] m_img = '0;
  bit            m_fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_job = 0; m_owner = 0; m_t = 0; m_dec = 0; m_r = 0;
      m_res = '0; m_err = 0; m_last = 1; m_tocnt = 0; m_img = '0;
    end else if (!m_job) begin
      if (jif.req != 2'b00) begin
        m_owner = (jif.req == 2'b11) ? !m_last : jif.req[1];
        m_img = m_owner ? jif.img1 : jif.img0;
        m_job = 1; m_t = 0; m_dec = 0;
      end
    end else begin
      m_fin = 0;
      if (!m_dec && m_t >= 1) begin
        if (eng_result_ready) begin
          m_res = eng_result; m_err = 0; m_dec = 1; m_r = m_t;
        end else if (m_t == TO) begin
          m_res = 4'hF; m_err = 1; m_dec = 1; m_r = m_t;
          if (m_tocnt < 255) m_tocnt++;
        end
      end else if (m_dec && m_t >= m_r + 2 &&
                   jif.resp_ready[m_owner]) begin
        m_job = 0; m_last = m_owner; m_fin = 1;
      end
      if (!m_fin) m_t++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_ack, e_rv;
    e_ack = (m_job && m_t == 0) ? oh(m_owner) : 2'b00;
    e_rv = (m_job && m_dec && m_t >= m_r + 2) ? oh(m_owner) : 2'b00;
    chk("ack", jif.ack, e_ack);
    chk("resp_valid", jif.resp_valid, e_rv);
    chk("eng_enable", eng_enable, m_job && !m_dec);
    chk("eng_buffer_full", eng_buffer_full, m_job && !m_dec);
    chk("eng_clear", eng_clear, m_job && m_dec && m_t == m_r + 1);
    chk("busy", busy, m_job);
    chk("resp_result", jif.resp_result, m_res);
    chk("resp_error", jif.resp_error, m_err);
    chk("timeout_cnt", timeout_cnt, m_tocnt);
    chk_img("eng_img", eng_img, m_img);
    chk("onehot", ($countones(jif.ack) <= 1) &&
                  ($countones(jif.resp_valid) <= 1), 1);
  end

  // Engine stand-in: raises result `e_dly` cycles after enable rises.
  int         e_dly = 1000;
  logic [3:0] e_val = '0;
  bit         e_noise = 0;
  bit         rnd_mode = 0;

  initial begin
    int age;
    age = 0;
    eng_result_ready = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || eng_clear) begin
        eng_result_ready = 1'b0;
        age = 0;
        if (rnd_mode) begin
          e_dly = $urandom_range(0, 20);
          e_val = 4'($urandom_range(0, 9));
        end
      end else if (eng_enable) begin
        if (age == e_dly) begin
          eng_result_ready = 1'b1;
          eng_result = e_val;
        end
        age++;
      end else begin
        age = 0;
        eng_result_ready = e_noise && ($urandom_range(0, 7) == 0);
        eng_result = 4'($urandom);
      end
    end
  end

  task automatic serve(output int who, output logic [3:0] res,
                       output logic err);
    int n;
    who = 0; res = '0; err = 0;
    n = 0;
    while (jif.ack == 2'b00 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("ack_wait", jif.ack != 2'b00, 1);
    who = int'(jif.ack[1]);
    jif.req[who] = 1'b0;
    n = 0;
    while (jif.resp_valid == 2'b00 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("resp_wait", jif.resp_valid != 2'b00, 1);
    res = jif.resp_result;
    err = jif.resp_error;
    jif.resp_ready = oh(who[0]);
    @(negedge clk);
    jif.resp_ready = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int w0, w1, w2, w3, n, nclr;
    logic [3:0] r;
    logic e;
    jif.req = 2'b00;
    jif.img0 = '0;
    jif.img1 = '0;
    jif.resp_ready = 2'b00;

    repeat (3) @(negedge clk);
    chk("rst_ack", jif.ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", eng_enable, 0);
    chk("rst_tocnt", timeout_cnt, 0);
    chk_img("rst_img", eng_img, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // single job, result 7 after 10 cycles
    jif.img0 = rand_img();
    e_dly = 10; e_val = 4'd7;
    jif.req = 2'b01;
    @(negedge clk);
    chk("single_ack", jif.ack, 2'b01);
    chk_img("single_img", eng_img, jif.img0);
    jif.req = 2'b00;
    @(negedge clk);
    chk("single_ack_pulse", jif.ack, 0);
    n = 0; nclr = 0;
    while (jif.resp_valid == 2'b00 && n < 100) begin
      if (eng_clear) nclr++;
      @(negedge clk); n++;
    end
    chk("single_clear_pulse", nclr, 1);
    chk("single_rv", jif.resp_valid, 2'b01);
    chk("single_res", jif.resp_result, 7);
    chk("single_err", jif.resp_error, 0);
    jif.resp_ready = 2'b01;
    @(negedge clk);
    jif.resp_ready = 2'b00;

    // minimum latency, requester 1
    jif.img1 = rand_img();
    e_dly = 1; e_val = 4'd3;
    jif.req = 2'b10;
    @(negedge clk);
    chk("lat_ack", jif.ack, 2'b10);
    jif.req = 2'b00;
    @(negedge clk);
    chk("lat_run", eng_enable, 1);
    @(negedge clk);
    chk("lat_clear", eng_clear, 1);
    @(negedge clk);
    chk("lat_rv", jif.resp_valid, 2'b10);
    chk("lat_res", jif.resp_result, 3);
    jif.resp_ready = 2'b10;
    @(negedge clk);
    jif.resp_ready = 2'b00;

    // contention from reset: 0,1 then 0,1
    do_reset();
    jif.img0 = rand_img(); jif.img1 = rand_img();
    e_dly = 2; e_val = 4'd5;
    jif.req = 2'b11;
    serve(w0, r, e);
    serve(w1, r, e);
    jif.req = 2'b11;
    serve(w2, r, e);
    serve(w3, r, e);
    chk("cont_0", w0, 0);
    chk("cont_1", w1, 1);
    chk("cont_2", w2, 0);
    chk("cont_3", w3, 1);
    chk("cont_model_last", m_last, 1);

    // timeout, then result exactly on the last cycle, then one late
    e_dly = 1000;
    jif.req = 2'b01;
    serve(w0, r, e);
    chk("to_res", r, 4'hF);
    chk("to_err", e, 1);
    chk("to_cnt", timeout_cnt, 1);
    chk("to_model_cnt", m_tocnt, 1);
    e_dly = TO; e_val = 4'd9;
    jif.req = 2'b01;
    serve(w0, r, e);
    chk("edge_res", r, 9);
    chk("edge_err", e, 0);
    chk("edge_cnt", timeout_cnt, 1);
    e_dly = TO + 1;
    jif.req = 2'b10;
    serve(w0, r, e);
    chk("late_res", r, 4'hF);
    chk("late_cnt", timeout_cnt, 2);

    // saturation
    e_dly = 1000;
    for (int j = 0; j < 300; j++) begin
      jif.req = 2'b01;
      serve(w0, r, e);
    end
    chk("sat_cnt", timeout_cnt, 255);
    chk("sat_model_cnt", m_tocnt, 255);

    // random traffic with engine noise outside RUN
    rnd_mode = 1; e_noise = 1;
    e_dly = 4;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (jif.ack[i]) jif.req[i] = 1'b0;
        else if (!jif.req[i] && $urandom_range(0, 3) == 0) begin
          if (i == 0) jif.img0 = rand_img();
          else        jif.img1 = rand_img();
          jif.req[i] = 1'b1;
        end
      end
      jif.resp_ready = 2'($urandom);
    end
    jif.req = 2'b00;
    e_noise = 0;
    jif.resp_ready = 2'b11;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain", busy, 0);
    rnd_mode = 0;
    jif.resp_ready = 2'b00;
    @(negedge clk);

    // backpressure: owner 0 stalls, non-owner ready and new req ignored
    e_dly = 2; e_val = 4'd4;
    jif.req = 2'b01;
    n = 0;
    while (jif.resp_valid == 2'b00 && n < 100) begin
      @(negedge clk); n++;
      if (jif.ack[0]) jif.req[0] = 1'b0;
    end
    chk("bp_rv_wait", jif.resp_valid, 2'b01);
    jif.img1 = rand_img();
    jif.req = 2'b10;
    jif.resp_ready = 2'b10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_rv", jif.resp_valid, 2'b01);
      chk("bp_noack", jif.ack, 0);
      chk("bp_res", jif.resp_result, 4);
    end
    jif.resp_ready = 2'b01;
    @(negedge clk);
    jif.resp_ready = 2'b00;
    e_dly = 3; e_val = 4'd6;
    serve(w0, r, e);
    chk("bp_next_owner", w0, 1);
    chk("bp_next_res", r, 6);

    // reset in the middle of RUN
    e_dly = 1000;
    jif.req = 2'b01;
    n = 0;
    while (jif.ack == 2'b00 && n < 20) begin
      @(negedge clk); n++;
    end
    jif.req = 2'b00;
    repeat (4) @(negedge clk);
    chk("mid_run", eng_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_en", eng_enable, 0);
    chk("mr_full", eng_buffer_full, 0);
    chk("mr_clear", eng_clear, 0);
    chk("mr_ack", jif.ack, 0);
    chk("mr_rv", jif.resp_valid, 0);
    chk("mr_res", jif.resp_result, 0);
    chk("mr_err", jif.resp_error, 0);
    chk("mr_tocnt", timeout_cnt, 0);
    chk_img("mr_img", eng_img, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    jif.resp_ready = 2'b11;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {jif.ack, jif.resp_valid}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
